// File: rtl/rv2t_machine_timer_access_if.sv
// Request/response bundle between the CSR decode stage
// and the machine timer access block.
`ifndef XLEN
`define XLEN 32
`endif

interface rv2t_machine_timer_access_if;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [1:0]       req_addr;
  logic [`XLEN-1:0] req_wdata;
  logic             rsp_valid;
  logic [`XLEN-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv2t_machine_timer_access.sv
// Machine timer register access: strobes, parked read address, irq.
// MTIMECMP_ATOMIC_WRITE_EN: buffer mtimecmp_lo, commit both on hi write.
`ifndef XLEN
`define XLEN 32
`endif

module rv2t_machine_timer_access #(
  parameter logic [1:0] IDLE_READ_ADDR = 2'b10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  rv2t_machine_timer_access_if.slave bus,
  output logic                 load_mtimecmp_low,
  output logic                 load_mtimecmp_high,
  output logic [`XLEN-1:0]     mtimecmp_write_data,
  output logic [1:0]           reg_read_addr,
  input  logic [`XLEN-1:0]     reg_read_data,
  input  logic                 timer_triggered,
  input  logic                 mtie,
  output logic                 timer_irq
);

`ifdef MTIMECMP_ATOMIC_WRITE_EN
  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_CAPTURE, WR_COMMIT, WR_HIGH
  } state_t;
  logic [`XLEN-1:0] lo_buf;
  logic [`XLEN-1:0] hi_buf;
`else
  typedef enum logic [1:0] {
    IDLE, RD_ISSUE, RD_CAPTURE, WR_COMMIT
  } state_t;
`endif

  state_t state;
  logic   mask;
  logic   err_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      bus.req_ready       <= 1'b1;
      bus.rsp_valid       <= 1'b0;
      bus.rsp_rdata       <= '0;
      bus.rsp_err         <= 1'b0;
      load_mtimecmp_low   <= 1'b0;
      load_mtimecmp_high  <= 1'b0;
      mtimecmp_write_data <= '0;
      reg_read_addr       <= IDLE_READ_ADDR;
      timer_irq           <= 1'b0;
      mask                <= 1'b0;
      err_pend            <= 1'b0;
`ifdef MTIMECMP_ATOMIC_WRITE_EN
      lo_buf              <= '0;
      hi_buf              <= '0;
`endif
    end else if (sync_reset) begin
      state               <= IDLE;
      bus.req_ready       <= 1'b1;
      bus.rsp_valid       <= 1'b0;
      bus.rsp_rdata       <= '0;
      bus.rsp_err         <= 1'b0;
      load_mtimecmp_low   <= 1'b0;
      load_mtimecmp_high  <= 1'b0;
      mtimecmp_write_data <= '0;
      reg_read_addr       <= IDLE_READ_ADDR;
      timer_irq           <= 1'b0;
      mask                <= 1'b0;
      err_pend            <= 1'b0;
`ifdef MTIMECMP_ATOMIC_WRITE_EN
      lo_buf              <= '0;
      hi_buf              <= '0;
`endif
    end else begin
      // mask hides the trigger the timer has not yet cleared after a load
      timer_irq     <= timer_triggered & mtie & ~mask;
      bus.rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            unique case (1'b1)
              !bus.req_write: begin
                reg_read_addr <= bus.req_addr;
                state         <= RD_ISSUE;
              end
              bus.req_write && !bus.req_addr[1]: begin
                err_pend <= 1'b1;
                state    <= WR_COMMIT;
              end
              bus.req_write && bus.req_addr[1]: begin
                err_pend <= 1'b0;
                state    <= WR_COMMIT;
`ifdef MTIMECMP_ATOMIC_WRITE_EN
                if (!bus.req_addr[0]) begin
                  lo_buf <= bus.req_wdata;
                end else begin
                  load_mtimecmp_low   <= 1'b1;
                  mtimecmp_write_data <= lo_buf;
                  hi_buf              <= bus.req_wdata;
                  mask                <= 1'b1;
                  state               <= WR_HIGH;
                end
`else
                load_mtimecmp_low   <= ~bus.req_addr[0];
                load_mtimecmp_high  <= bus.req_addr[0];
                mtimecmp_write_data <= bus.req_wdata;
                mask                <= 1'b1;
`endif
              end
            endcase
          end
        end
        // park the address so only RD_ISSUE of addr 0 refreshes mtime_hi
        RD_ISSUE: begin
          reg_read_addr <= IDLE_READ_ADDR;
          state         <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          bus.rsp_rdata <= reg_read_data;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.req_ready <= 1'b1;
          reg_read_addr <= IDLE_READ_ADDR;
          state         <= IDLE;
        end
`ifdef MTIMECMP_ATOMIC_WRITE_EN
        WR_HIGH: begin
          load_mtimecmp_low   <= 1'b0;
          load_mtimecmp_high  <= 1'b1;
          mtimecmp_write_data <= hi_buf;
          state               <= WR_COMMIT;
        end
`endif
        WR_COMMIT: begin
          load_mtimecmp_low  <= 1'b0;
          load_mtimecmp_high <= 1'b0;
          mask               <= 1'b0;
          bus.rsp_valid      <= 1'b1;
          bus.rsp_rdata      <= '0;
          bus.rsp_err        <= err_pend;
          bus.req_ready      <= 1'b1;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
